// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 responder backed by a word-addressed register-array memory.
// Independent write (AW/W/B) and read (AR/R) state machines serve one write burst and
// one read burst concurrently. Supports FIXED and INCR bursts. Unsupported bursts,
// unsupported sizes and out-of-range beats answer SLVERR.
// WRAP bursts are enabled by defining AXI_SRAM_SLAVE_WRAP_EN. Without it, WRAP is
// treated as unsupported.
//
// Ports:
//   clk_i      - clock, all logic on the rising edge
//   rst_ni     - asynchronous active-low reset
//   slv_req_i  - AW/W/AR payloads and valids, B/R readys
//   slv_resp_o - AW/W/AR readys, B/R payloads and valids
//
// The memory contents are not reset.

package axi_sram_slave_pkg;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned UserWidth = 1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        logic [UserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;
endpackage

module axi_sram_slave #(
    parameter int unsigned AddrWidth = axi_sram_slave_pkg::AddrWidth,
    parameter int unsigned DataWidth = axi_sram_slave_pkg::DataWidth,
    parameter int unsigned IdWidth   = axi_sram_slave_pkg::IdWidth,
    parameter int unsigned NumWords  = 1024,
    parameter type aw_chan_t  = axi_sram_slave_pkg::aw_chan_t,
    parameter type w_chan_t   = axi_sram_slave_pkg::w_chan_t,
    parameter type b_chan_t   = axi_sram_slave_pkg::b_chan_t,
    parameter type ar_chan_t  = axi_sram_slave_pkg::ar_chan_t,
    parameter type r_chan_t   = axi_sram_slave_pkg::r_chan_t,
    parameter type axi_req_t  = axi_sram_slave_pkg::axi_req_t,
    parameter type axi_resp_t = axi_sram_slave_pkg::axi_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffBits   = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = $clog2(NumWords);
`ifdef AXI_SRAM_SLAVE_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    // Beat is served only for a supported burst/size and a word inside the array.
    function automatic logic beat_ok(input logic [AddrWidth-1:0] addr, input logic [1:0] burst,
                                     input logic [7:0] len, input logic [2:0] size);
        logic ok;
        ok = 1'b0;
        case (burst)
            BurstFixed, BurstIncr: ok = 1'b1;
            BurstWrap:             ok = WrapEn && (len inside {8'd1, 8'd3, 8'd7, 8'd15});
            default:               ok = 1'b0;
        endcase
        return ok && (32'(size) <= OffBits) && ((addr >> OffBits) < AddrWidth'(NumWords));
    endfunction

    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] addr,
                                                       input logic [1:0] burst,
                                                       input logic [7:0] len, input logic [2:0] size);
        logic [AddrWidth-1:0] step;
        logic [AddrWidth-1:0] wrap_sz;
        logic [AddrWidth-1:0] nxt;
        step    = AddrWidth'(1) << size;
        wrap_sz = (AddrWidth'(len) + AddrWidth'(1)) << size;
        nxt     = (addr & ~(step - AddrWidth'(1))) + step;
        if (burst == BurstFixed) begin
            nxt = addr;
        end else if (burst == BurstWrap) begin
            nxt = (addr & ~(wrap_sz - AddrWidth'(1))) | (nxt & (wrap_sz - AddrWidth'(1)));
        end
        return nxt;
    endfunction

    aw_chan_t aw;
    w_chan_t  w;
    ar_chan_t ar;
    b_chan_t  b;
    r_chan_t  r;
    assign aw = slv_req_i.aw;
    assign w  = slv_req_i.w;
    assign ar = slv_req_i.ar;

    logic unused_user;
    assign unused_user = ^{aw.user, w.user, ar.user};

    logic [DataWidth-1:0] mem [NumWords];

    // ---------------- write side ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    w_state_e w_state_q, w_state_d;

    logic [IdWidth-1:0]   w_id;
    logic [AddrWidth-1:0] w_addr;
    logic [7:0]           w_len, w_cnt;
    logic [2:0]           w_size;
    logic [1:0]           w_burst;
    logic                 w_err;
    logic aw_ready, w_ready, b_valid;
    logic aw_hs, w_hs, w_last_beat, w_beat_ok;
    logic [IdxWidth-1:0]  w_idx;

    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_ok   = beat_ok(w_addr, w_burst, w_len, w_size);
    assign w_idx       = w_addr[OffBits +: IdxWidth];
    assign aw_hs       = aw_ready && slv_req_i.aw_valid;
    assign w_hs        = w_ready && slv_req_i.w_valid;

    always_comb begin
        w_state_d = w_state_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready = 1'b1;
                if (slv_req_i.aw_valid) w_state_d = W_DATA;
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (slv_req_i.w_valid && w_last_beat) w_state_d = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (slv_req_i.b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            w_id      <= '0;
            w_addr    <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_size    <= '0;
            w_burst   <= '0;
            w_err     <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) begin
                w_id    <= aw.id;
                w_addr  <= aw.addr;
                w_len   <= aw.len;
                w_size  <= aw.size;
                w_burst <= aw.burst;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end else if (w_hs) begin
                w_cnt  <= w_cnt + 8'd1;
                w_addr <= next_addr(w_addr, w_burst, w_len, w_size);
                // w.last must coincide exactly with the final beat counted from len.
                if (!w_beat_ok || (w.last != w_last_beat)) w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_hs && w_beat_ok) begin
            for (int unsigned i = 0; i < StrbWidth; i++) begin
                if (w.strb[i]) mem[w_idx][i*8 +: 8] <= w.data[i*8 +: 8];
            end
        end
    end

    // ---------------- read side ----------------
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    r_state_e r_state_q, r_state_d;

    logic [IdWidth-1:0]   r_id;
    logic [AddrWidth-1:0] r_addr, r_nxt_addr;
    logic [7:0]           r_len, r_cnt;
    logic [2:0]           r_size;
    logic [1:0]           r_burst;
    logic [DataWidth-1:0] r_data;
    logic                 r_err;
    logic ar_ready, r_valid;
    logic ar_hs, r_hs, r_last, ar_beat_ok, r_nxt_ok;

    assign r_last     = (r_cnt == r_len);
    assign ar_hs      = ar_ready && slv_req_i.ar_valid;
    assign r_hs       = r_valid && slv_req_i.r_ready;
    assign ar_beat_ok = beat_ok(ar.addr, ar.burst, ar.len, ar.size);
    assign r_nxt_addr = next_addr(r_addr, r_burst, r_len, r_size);
    assign r_nxt_ok   = beat_ok(r_nxt_addr, r_burst, r_len, r_size);

    always_comb begin
        r_state_d = r_state_q;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (slv_req_i.ar_valid) r_state_d = R_DATA;
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (slv_req_i.r_ready && r_last) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // The word for each beat is fetched on the edge that accepts AR or the previous
    // beat, so R payload is a plain register and stays stable under back-pressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                r_id    <= ar.id;
                r_addr  <= ar.addr;
                r_len   <= ar.len;
                r_size  <= ar.size;
                r_burst <= ar.burst;
                r_cnt   <= '0;
                r_data  <= ar_beat_ok ? mem[ar.addr[OffBits +: IdxWidth]] : '0;
                r_err   <= !ar_beat_ok;
            end else if (r_hs && !r_last) begin
                r_addr <= r_nxt_addr;
                r_cnt  <= r_cnt + 8'd1;
                r_data <= r_nxt_ok ? mem[r_nxt_addr[OffBits +: IdxWidth]] : '0;
                r_err  <= !r_nxt_ok;
            end
        end
    end

    // ---------------- response assembly ----------------
    always_comb begin
        b = '0;
        r = '0;
        if (b_valid) begin
            b.id   = w_id;
            b.resp = w_err ? RespSlvErr : RespOkay;
        end
        if (r_valid) begin
            r.id   = r_id;
            r.data = r_data;
            r.resp = r_err ? RespSlvErr : RespOkay;
            r.last = r_last;
        end
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.b_valid  = b_valid;
        slv_resp_o.b        = b;
        slv_resp_o.r_valid  = r_valid;
        slv_resp_o.r        = r;
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
    import axi_sram_slave_pkg::*;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;

    logic      clk;
    logic      rst_n;
    axi_req_t  req;
    axi_resp_t resp;

    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;

    int tests;
    int failed;

    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id;
    int unsigned rd_wait;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req.aw       = aw;
        req.aw_valid = aw_valid;
        req.w        = w;
        req.w_valid  = w_valid;
        req.b_ready  = b_ready;
        req.ar       = ar;
        req.ar_valid = ar_valid;
        req.r_ready  = r_ready;
    end

    axi_sram_slave dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (req),
        .slv_resp_o (resp)
    );

    initial begin
        #200us;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
        int unsigned n;
        aw = '0; aw.addr = addr; aw.len = len; aw.size = 3'd3; aw.burst = burst; aw.id = id;
        aw_valid = 1'b1;
        n = 0;
        while (!resp.aw_ready && n < 50) begin tick(); n++; end
        if (!resp.aw_ready) begin
            tests++; failed++;
            $display("FAIL aw_timeout: aw_ready=%b required 1", resp.aw_ready);
        end
        tick();
        aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
        int unsigned n;
        ar = '0; ar.addr = addr; ar.len = len; ar.size = 3'd3; ar.burst = burst; ar.id = id;
        ar_valid = 1'b1;
        n = 0;
        while (!resp.ar_ready && n < 50) begin tick(); n++; end
        if (!resp.ar_ready) begin
            tests++; failed++;
            $display("FAIL ar_timeout: ar_ready=%b required 1", resp.ar_ready);
        end
        tick();
        ar_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last,
                          output int unsigned waited);
        w = '0; w.data = data; w.strb = strb; w.last = last;
        w_valid = 1'b1;
        waited = 0;
        while (!resp.w_ready && waited < 50) begin tick(); waited++; end
        if (!resp.w_ready) begin
            tests++; failed++;
            $display("FAIL w_timeout: w_ready=%b required 1", resp.w_ready);
        end
        tick();
        w_valid = 1'b0;
    endtask

    task automatic wait_b(output logic [3:0] id, output logic [1:0] rsp, output int unsigned waited);
        b_ready = 1'b1;
        waited = 0;
        while (!resp.b_valid && waited < 50) begin tick(); waited++; end
        if (!resp.b_valid) begin
            tests++; failed++;
            $display("FAIL b_timeout: b_valid=%b required 1", resp.b_valid);
        end
        id  = resp.b.id;
        rsp = resp.b.resp;
        tick();
        b_ready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input logic [63:0] base, input logic [7:0] strb,
                            output logic [1:0] rsp);
        int unsigned wt;
        logic [3:0]  bid;
        send_aw(addr, len, burst, id);
        for (int i = 0; i <= int'(len); i++) send_w(base + 64'(i), strb, (i == int'(len)), wt);
        wait_b(bid, rsp, wt);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [3:0] id);
        int unsigned n;
        send_ar(addr, len, burst, id);
        r_ready = 1'b1;
        rd_wait = 0;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!resp.r_valid && n < 50) begin tick(); n++; rd_wait++; end
            if (!resp.r_valid) begin
                tests++; failed++;
                $display("FAIL r_timeout beat %0d: r_valid=%b required 1", i, resp.r_valid);
            end
            rd_data[i] = resp.r.data;
            rd_resp[i] = resp.r.resp;
            rd_last[i] = resp.r.last;
            rd_id      = resp.r.id;
            tick();
        end
        r_ready = 1'b0;
    endtask

    task automatic test_reset();
        aw = '0; w = '0; ar = '0;
        aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (resp.aw_ready !== 1'b1) begin failed++; $display("FAIL rst_aw_ready: got %b required 1", resp.aw_ready); end
        tests++; if (resp.ar_ready !== 1'b1) begin failed++; $display("FAIL rst_ar_ready: got %b required 1", resp.ar_ready); end
        tests++; if (resp.w_ready !== 1'b0) begin failed++; $display("FAIL rst_w_ready: got %b required 0", resp.w_ready); end
        tests++; if (resp.b_valid !== 1'b0) begin failed++; $display("FAIL rst_b_valid: got %b required 0", resp.b_valid); end
        tests++; if (resp.r_valid !== 1'b0) begin failed++; $display("FAIL rst_r_valid: got %b required 0", resp.r_valid); end
        tests++; if (resp.b !== '0) begin failed++; $display("FAIL rst_b_payload: got %h required 0", resp.b); end
        tests++; if (resp.r !== '0) begin failed++; $display("FAIL rst_r_payload: got %h required 0", resp.r); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_incr_burst();
        int unsigned wt;
        int unsigned wsum;
        logic [3:0]  bid;
        logic [1:0]  brsp;
        // W offered before any AW must stall
        w = '0; w.data = 64'h55; w.strb = 8'hFF; w_valid = 1'b1;
        tick(); tick();
        tests++; if (resp.w_ready !== 1'b0) begin failed++; $display("FAIL w_stall_before_aw: w_ready=%b required 0", resp.w_ready); end
        w_valid = 1'b0;
        send_aw(32'h100, 8'd3, INCR, 4'd5);
        tests++; if (resp.w_ready !== 1'b1) begin failed++; $display("FAIL w_ready_after_aw: got %b required 1", resp.w_ready); end
        wsum = 0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (resp.b_valid !== 1'b0) begin failed++; $display("FAIL b_early beat %0d: b_valid=%b required 0", i, resp.b_valid); end
            send_w(64'hA0 + 64'(i), 8'hFF, (i == 3), wt);
            wsum += wt;
        end
        tests++; if (wsum !== 0) begin failed++; $display("FAIL w_throughput: stall cycles %0d required 0", wsum); end
        tests++; if (resp.b_valid !== 1'b1) begin failed++; $display("FAIL b_valid_latency: got %b required 1", resp.b_valid); end
        wait_b(bid, brsp, wt);
        tests++; if (bid !== 4'd5) begin failed++; $display("FAIL b_id: got %h required 5", bid); end
        tests++; if (brsp !== 2'b00) begin failed++; $display("FAIL b_resp_incr: got %b required 00", brsp); end
        tests++; if (resp.aw_ready !== 1'b1) begin failed++; $display("FAIL aw_ready_after_b: got %b required 1", resp.aw_ready); end

        read_burst(32'h100, 8'd3, INCR, 4'd7);
        tests++; if (rd_wait !== 0) begin failed++; $display("FAIL r_throughput: stall cycles %0d required 0", rd_wait); end
        tests++; if (rd_id !== 4'd7) begin failed++; $display("FAIL r_id: got %h required 7", rd_id); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (rd_data[i] !== 64'hA0 + 64'(i)) begin failed++; $display("FAIL r_data_incr beat %0d: got %h required %h", i, rd_data[i], 64'hA0 + 64'(i)); end
            tests++; if (rd_last[i] !== (i == 3)) begin failed++; $display("FAIL r_last_incr beat %0d: got %b required %b", i, rd_last[i], (i == 3)); end
            tests++; if (rd_resp[i] !== 2'b00) begin failed++; $display("FAIL r_resp_incr beat %0d: got %b required 00", i, rd_resp[i]); end
        end
        tests++; if (resp.ar_ready !== 1'b1) begin failed++; $display("FAIL ar_ready_after_last: got %b required 1", resp.ar_ready); end
    endtask

    task automatic test_narrow_strb();
        logic [1:0] brsp;
        do_write(32'h200, 8'd0, INCR, 4'd1, 64'h1122_3344_5566_7788, 8'hFF, brsp);
        do_write(32'h200, 8'd0, INCR, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, brsp);
        tests++; if (brsp !== 2'b00) begin failed++; $display("FAIL strb_b_resp: got %b required 00", brsp); end
        read_burst(32'h200, 8'd0, INCR, 4'd1);
        tests++; if (rd_data[0] !== 64'h1122_3344_FFFF_FFFF) begin failed++; $display("FAIL strb_merge: got %h required 1122_3344_ffff_ffff", rd_data[0]); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] brsp;
        do_write(32'h1FF8, 8'd0, INCR, 4'd2, 64'hCAFE_F00D_1234_5678, 8'hFF, brsp);
        tests++; if (brsp !== 2'b00) begin failed++; $display("FAIL top_word_write: got %b required 00", brsp); end
        read_burst(32'h1FF8, 8'd1, INCR, 4'd3);
        tests++; if (rd_data[0] !== 64'hCAFE_F00D_1234_5678) begin failed++; $display("FAIL oor_beat0_data: got %h required cafef00d12345678", rd_data[0]); end
        tests++; if (rd_resp[0] !== 2'b00) begin failed++; $display("FAIL oor_beat0_resp: got %b required 00", rd_resp[0]); end
        tests++; if (rd_data[1] !== 64'h0) begin failed++; $display("FAIL oor_beat1_data: got %h required 0", rd_data[1]); end
        tests++; if (rd_resp[1] !== 2'b10) begin failed++; $display("FAIL oor_beat1_resp: got %b required 10", rd_resp[1]); end
        tests++; if (rd_last[1] !== 1'b1) begin failed++; $display("FAIL oor_beat1_last: got %b required 1", rd_last[1]); end
        do_write(32'h1FF8, 8'd1, INCR, 4'd2, 64'h0, 8'hFF, brsp);
        tests++; if (brsp !== 2'b10) begin failed++; $display("FAIL oor_write_resp: got %b required 10", brsp); end
    endtask

    task automatic test_last_mismatch();
        int unsigned wt;
        int unsigned wsum;
        logic [3:0]  bid;
        logic [1:0]  brsp;
        send_aw(32'h600, 8'd3, INCR, 4'd6);
        wsum = 0;
        for (int i = 0; i < 4; i++) begin
            send_w(64'h60 + 64'(i), 8'hFF, (i == 1), wt);
            wsum += wt;
        end
        tests++; if (wsum !== 0) begin failed++; $display("FAIL early_last_accept: stall cycles %0d required 0", wsum); end
        wait_b(bid, brsp, wt);
        tests++; if (brsp !== 2'b10) begin failed++; $display("FAIL early_last_resp: got %b required 10", brsp); end
        tests++; if (bid !== 4'd6) begin failed++; $display("FAIL early_last_id: got %h required 6", bid); end
        send_aw(32'h640, 8'd1, INCR, 4'd6);
        send_w(64'h1, 8'hFF, 1'b0, wt);
        send_w(64'h2, 8'hFF, 1'b0, wt);
        wait_b(bid, brsp, wt);
        tests++; if (brsp !== 2'b10) begin failed++; $display("FAIL missing_last_resp: got %b required 10", brsp); end
    endtask

    task automatic test_back_to_back_stall();
        logic [1:0] brsp;
        do_write(32'h300, 8'd3, INCR, 4'd1, 64'hB0, 8'hFF, brsp);
        fork
            begin
                send_ar(32'h300, 8'd3, INCR, 4'd9);
                r_ready = 1'b1;
                tests++; if (resp.r.data !== 64'hB0) begin failed++; $display("FAIL stall_beat0: got %h required b0", resp.r.data); end
                tick();
                r_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tests++;
                    if (resp.r_valid !== 1'b1 || resp.r.data !== 64'hB1 || resp.r.last !== 1'b0) begin
                        failed++;
                        $display("FAIL stall_hold cycle %0d: valid=%b data=%h last=%b required 1/b1/0", k, resp.r_valid, resp.r.data, resp.r.last);
                    end
                    tick();
                end
                r_ready = 1'b1;
                tests++; if (resp.r.data !== 64'hB1) begin failed++; $display("FAIL stall_beat1: got %h required b1", resp.r.data); end
                tick();
                tests++; if (resp.r.data !== 64'hB2 || resp.r.last !== 1'b0) begin failed++; $display("FAIL stall_beat2: data=%h last=%b required b2/0", resp.r.data, resp.r.last); end
                tick();
                tests++; if (resp.r.data !== 64'hB3 || resp.r.last !== 1'b1) begin failed++; $display("FAIL stall_beat3: data=%h last=%b required b3/1", resp.r.data, resp.r.last); end
                tick();
                r_ready = 1'b0;
            end
            begin
                int unsigned wt;
                logic [3:0]  bid;
                logic [1:0]  cr;
                send_aw(32'h400, 8'd1, INCR, 4'hC);
                send_w(64'hD0, 8'hFF, 1'b0, wt);
                send_w(64'hD1, 8'hFF, 1'b1, wt);
                wait_b(bid, cr, wt);
                tests++; if (bid !== 4'hC || cr !== 2'b00 || wt !== 0) begin failed++; $display("FAIL concurrent_b: id=%h resp=%b wait=%0d required c/00/0", bid, cr, wt); end
            end
        join
        read_burst(32'h400, 8'd1, INCR, 4'd0);
        tests++; if (rd_data[0] !== 64'hD0 || rd_data[1] !== 64'hD1) begin failed++; $display("FAIL concurrent_data: got %h %h required d0 d1", rd_data[0], rd_data[1]); end
    endtask

    task automatic test_same_cycle();
        logic [1:0] brsp;
        do_write(32'h500, 8'd0, INCR, 4'd1, 64'h1111, 8'hFF, brsp);
        send_aw(32'h500, 8'd0, INCR, 4'd2);
        w = '0; w.data = 64'h2222; w.strb = 8'hFF; w.last = 1'b1; w_valid = 1'b1;
        ar = '0; ar.addr = 32'h500; ar.size = 3'd3; ar.burst = INCR; ar.id = 4'd3; ar_valid = 1'b1;
        tests++; if ({resp.w_ready, resp.ar_ready} !== 2'b11) begin failed++; $display("FAIL same_cycle_ready: got %b required 11", {resp.w_ready, resp.ar_ready}); end
        tick();
        w_valid = 1'b0; ar_valid = 1'b0;
        tests++; if (resp.r_valid !== 1'b1 || resp.r.data !== 64'h1111) begin failed++; $display("FAIL same_cycle_old: valid=%b data=%h required 1/1111", resp.r_valid, resp.r.data); end
        r_ready = 1'b1; b_ready = 1'b1;
        tick();
        r_ready = 1'b0; b_ready = 1'b0;
        read_burst(32'h500, 8'd0, INCR, 4'd3);
        tests++; if (rd_data[0] !== 64'h2222) begin failed++; $display("FAIL same_cycle_new: got %h required 2222", rd_data[0]); end
    endtask

    task automatic test_wrap();
        logic [1:0]  brsp;
        logic [63:0] exp_d [4];
        logic [1:0]  exp_r;
        logic [63:0] exp_first;
`ifdef AXI_SRAM_SLAVE_WRAP_EN
        exp_d[0] = 64'hA3; exp_d[1] = 64'hA0; exp_d[2] = 64'hA1; exp_d[3] = 64'hA2; exp_r = 2'b00;
`else
        exp_d[0] = 64'h0; exp_d[1] = 64'h0; exp_d[2] = 64'h0; exp_d[3] = 64'h0; exp_r = 2'b10;
`endif
        read_burst(32'h118, 8'd3, WRAP, 4'd4);
        for (int i = 0; i < 4; i++) begin
            tests++; if (rd_data[i] !== exp_d[i] || rd_resp[i] !== exp_r) begin failed++; $display("FAIL wrap_read beat %0d: data=%h resp=%b required %h/%b", i, rd_data[i], rd_resp[i], exp_d[i], exp_r); end
        end
        do_write(32'h118, 8'd3, WRAP, 4'd4, 64'hE0, 8'hFF, brsp);
        tests++; if (brsp !== exp_r) begin failed++; $display("FAIL wrap_write_resp: got %b required %b", brsp, exp_r); end
`ifdef AXI_SRAM_SLAVE_WRAP_EN
        exp_d[0] = 64'hE1; exp_d[1] = 64'hE2; exp_d[2] = 64'hE3; exp_d[3] = 64'hE0;
`else
        exp_d[0] = 64'hA0; exp_d[1] = 64'hA1; exp_d[2] = 64'hA2; exp_d[3] = 64'hA3;
`endif
        read_burst(32'h100, 8'd3, INCR, 4'd4);
        for (int i = 0; i < 4; i++) begin
            tests++; if (rd_data[i] !== exp_d[i]) begin failed++; $display("FAIL wrap_write_effect word %0d: got %h required %h", i, rd_data[i], exp_d[i]); end
        end
        exp_first = exp_d[0];
        read_burst(32'h100, 8'd2, WRAP, 4'd4);
        tests++; if (rd_resp[0] !== 2'b10 || rd_data[0] !== 64'h0) begin failed++; $display("FAIL wrap_bad_len: resp=%b data=%h required 10/0", rd_resp[0], rd_data[0]); end
        read_burst(32'h100, 8'd0, RSVD, 4'd4);
        tests++; if (rd_resp[0] !== 2'b10 || rd_data[0] !== 64'h0) begin failed++; $display("FAIL rsvd_read: resp=%b data=%h required 10/0", rd_resp[0], rd_data[0]); end
        do_write(32'h100, 8'd0, RSVD, 4'd4, 64'hFFFF, 8'hFF, brsp);
        tests++; if (brsp !== 2'b10) begin failed++; $display("FAIL rsvd_write_resp: got %b required 10", brsp); end
        read_burst(32'h100, 8'd0, FIXED, 4'd4);
        tests++; if (rd_data[0] !== exp_first || rd_resp[0] !== 2'b00) begin failed++; $display("FAIL rsvd_no_update: data=%h resp=%b required %h/00", rd_data[0], rd_resp[0], exp_first); end
    endtask

    task automatic test_reset_abort();
        int unsigned wt;
        send_aw(32'h700, 8'd3, INCR, 4'd1);
        send_w(64'h77, 8'hFF, 1'b0, wt);
        send_ar(32'h100, 8'd3, INCR, 4'd2);
        tests++; if (resp.r_valid !== 1'b1) begin failed++; $display("FAIL abort_pre_r_valid: got %b required 1", resp.r_valid); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid} !== 5'b11000) begin
            failed++;
            $display("FAIL abort_in_reset: aw/ar/w/b/r=%b required 11000", {resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        b_ready = 1'b1; r_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (resp.b_valid !== 1'b0 || resp.r_valid !== 1'b0) begin failed++; $display("FAIL abort_no_resp cycle %0d: b=%b r=%b required 0/0", k, resp.b_valid, resp.r_valid); end
        end
        b_ready = 1'b0; r_ready = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_incr_burst();
        test_narrow_strb();
        test_out_of_range();
        test_last_mismatch();
        test_back_to_back_stall();
        test_same_cycle();
        test_wrap();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
